// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Data-side bridge between a single-cycle MIPS core's load/store port and a
//   slow handshaked external data memory, plus a 16-byte MMIO window.
//
//   External accesses stall the core. The bridge runs the access as
//   IDLE -> REQ -> DONE:
//     - IDLE: the access is seen and latched.
//     - REQ:  mem_req stays high until mem_ack arrives or TIMEOUT cycles
//             pass without one.
//     - DONE: the latched read data is returned and the core advances.
//   MMIO and misaligned accesses complete in IDLE with no stall.
//
//   Handshake: mem_req rises the cycle after an external access is seen and
//   stays high (with mem_we/mem_addr/mem_wdata stable) until the edge where
//   mem_ack is sampled high, or the timeout fires. mem_ack is a one-cycle
//   pulse and is only honoured in REQ. mem_rdata is sampled with mem_ack.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_addr/wdata/read/write: core load/store port
//   cpu_rdata, cpu_stall     : load data and freeze request back to the core
//   mem_req/we/addr/wdata    : external request (held until ack)
//   mem_rdata, mem_ack       : external response
//   leds                     : MMIO LED register
//   err                      : sticky [0] misaligned, [1] timeout
//   fsm_state                : debug view of the FSM (0 IDLE, 1 REQ, 2 DONE)
module dmem_bridge #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] leds,
    output logic [1:0]  err,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        access, misaligned, in_mmio, is_ext, mmio_wr, mmio_rd;
    logic        timed_out, err_clear;
    logic [1:0]  err_next;
    logic [31:0] cycles, rdata_q, mmio_rdata, tcnt;

    assign fsm_state = state;

    // Access classification; a simultaneous read+write is a write.
    always_comb begin
        access     = cpu_read | cpu_write;
        misaligned = access && (cpu_addr[1:0] != 2'b00);
        in_mmio    = (cpu_addr[31:4] == MMIO_BASE[31:4]);
        is_ext     = access && !misaligned && !in_mmio;
        mmio_wr    = cpu_write && !misaligned && in_mmio && (state == S_IDLE);
        mmio_rd    = cpu_read && !cpu_write && !misaligned && in_mmio;
        timed_out  = (tcnt == 32'(TIMEOUT - 1));
    end

    always_comb begin
        mmio_rdata = 32'h0;
        case (cpu_addr[3:2])
            2'd0:    mmio_rdata = {16'h0, leds};
            2'd1:    mmio_rdata = cycles;
            2'd2:    mmio_rdata = {30'h0, err};
            default: mmio_rdata = 32'h0;
        endcase
    end

    // Sticky error flags: a new error in the clearing cycle still sets.
    always_comb begin
        err_clear = mmio_wr && (cpu_addr[3:2] == 2'd2);
        err_next  = err_clear ? 2'b00 : err;
        if (state == S_IDLE && misaligned)
            err_next[0] = 1'b1;
        if (state == S_REQ && !mem_ack && timed_out)
            err_next[1] = 1'b1;
    end

    // Next state and core-facing outputs.
    always_comb begin
        state_next = state;
        cpu_stall  = 1'b0;
        cpu_rdata  = 32'h0;
        case (state)
            S_IDLE: begin
                if (is_ext) begin
                    cpu_stall  = 1'b1;
                    state_next = S_REQ;
                end else if (mmio_rd) begin
                    cpu_rdata = mmio_rdata;
                end
            end
            S_REQ: begin
                cpu_stall = 1'b1;
                if (mem_ack || timed_out)
                    state_next = S_DONE;
            end
            S_DONE: begin
                // The access still present here belongs to the retiring
                // instruction, so it is not restarted.
                cpu_rdata  = rdata_q;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            leds      <= 16'h0;
            err       <= 2'b00;
            cycles    <= 32'h0;
            rdata_q   <= 32'h0;
            tcnt      <= 32'h0;
        end else begin
            state  <= state_next;
            cycles <= cycles + 32'd1;
            err    <= err_next;
            if (mmio_wr && cpu_addr[3:2] == 2'd0)
                leds <= cpu_wdata[15:0];
            case (state)
                S_IDLE: begin
                    if (is_ext) begin
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_write;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        tcnt      <= 32'h0;
                    end
                end
                S_REQ: begin
                    tcnt <= tcnt + 32'd1;
                    // An ack in the timeout cycle wins over the abort.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= mem_we ? 32'h0 : mem_rdata;
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        rdata_q <= 32'hDEAD_BEEF;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_read, cpu_write, cpu_stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] leds;
    logic [1:0]  err;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    // Reference state kept by the bench.
    logic [31:0] cyc_model;
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] exp_q [$];
    logic [15:0] leds_m;
    logic [1:0]  err_m;

    dmem_bridge #(.TIMEOUT(TIMEOUT), .MMIO_BASE(MMIO)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .leds(leds), .err(err), .fsm_state(fsm_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // The free-running counter is simply the number of clocks since reset.
    always @(posedge clk) begin
        if (rst) cyc_model <= 32'h0;
        else     cyc_model <= cyc_model + 32'd1;
    end

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_read = 1'b0; cpu_write = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        leds_m = 16'h0;
        err_m  = 2'b00;
    endtask

    // Driver: runs one instruction from posedge+1 to posedge+1 and acts as
    // the external memory, acking in REQ cycle ack_at (0 = never).
    task automatic do_access(
        input  logic rd, input logic wr, input logic [31:0] addr,
        input  logic [31:0] wdata, input int ack_at,
        output int cycles, output int req_cycles, output logic [31:0] rdata,
        output logic [31:0] req_addr, output logic req_we,
        output logic [31:0] req_wdata, output logic req_in_done);
        bit done;
        done = 0; cycles = 0; req_cycles = 0; rdata = 32'h0;
        req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0; req_in_done = 1'b0;
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
        while (!done && cycles < 40) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
                end
                if (req_cycles == ack_at) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_val(mem_addr);
                end
            end
            #1;
            cycles++;
            if (!cpu_stall) begin
                done = 1; rdata = cpu_rdata; req_in_done = mem_req;
            end
            @(posedge clk); #1;
        end
        cpu_read = 1'b0; cpu_write = 1'b0; mem_ack = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_bound: stall never dropped for addr %h within 40 cycles", addr);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (leds !== 16'h0) begin errors++; $display("FAIL reset_leds: got %h expected 0", leds); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
        checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem_bus: got addr %h we %b wdata %h expected zeros", mem_addr, mem_we, mem_wdata);
        end
        repeat (3) @(posedge clk);
        #1 cpu_read = 1'b1; cpu_addr = MMIO + 32'h4;
        #1;
        checks++; if (cpu_rdata !== 32'd3) begin errors++; $display("FAIL reset_cycles: got %0d expected 3", cpu_rdata); end
        @(posedge clk); #1 cpu_read = 1'b0;
    endtask

    task automatic test_ext_read();
        int cyc, nreq; logic [31:0] rd, ra, rw; logic we, rq;
        mem_arr[32'h100] = 32'h1234_5678;
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 2, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (cyc - 1 !== 3) begin errors++; $display("FAIL read_stall_cycles: got %0d expected 3", cyc - 1); end
        checks++; if (ra !== 32'h100 || we !== 1'b0) begin errors++; $display("FAIL read_req: got addr %h we %b expected 100 0", ra, we); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read_data: got %h expected 12345678", rd); end
    endtask

    task automatic test_ext_write();
        int cyc, nreq; logic [31:0] rd, ra, rw; logic we, rq;
        do_access(1'b0, 1'b1, 32'h200, 32'hA5A5_A5A5, 1, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL write_cycles: got %0d expected 3", cyc); end
        checks++; if (we !== 1'b1 || rw !== 32'hA5A5_A5A5 || ra !== 32'h200) begin
            errors++; $display("FAIL write_req: got we %b data %h addr %h expected 1 a5a5a5a5 200", we, rw, ra);
        end
        checks++; if (rq !== 1'b0) begin errors++; $display("FAIL write_req_drop: got %b expected 0", rq); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_rdata: got %h expected 0", rd); end
    endtask

    task automatic test_timeout();
        int cyc, nreq; logic [31:0] rd, ra, rw; logic we, rq;
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (nreq !== TIMEOUT || cyc !== TIMEOUT + 2) begin
            errors++; $display("FAIL timeout_len: got req %0d total %0d expected %0d %0d", nreq, cyc, TIMEOUT, TIMEOUT + 2);
        end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_data: got %h expected deadbeef", rd); end
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL timeout_err: got %b expected 10", err); end
        do_access(1'b0, 1'b1, MMIO + 32'h8, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL err_clear: got %b expected 00", err); end
        mem_arr[32'h304] = 32'h0BAD_F00D;
        do_access(1'b1, 1'b0, 32'h304, 32'h0, TIMEOUT, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (rd !== 32'h0BAD_F00D || err !== 2'b00 || cyc !== TIMEOUT + 2) begin
            errors++; $display("FAIL late_ack: got data %h err %b total %0d expected 0badf00d 00 %0d", rd, err, cyc, TIMEOUT + 2);
        end
    endtask

    task automatic test_mmio();
        int cyc, nreq; logic [31:0] rd, ra, rw, exp; logic we, rq;
        do_access(1'b0, 1'b1, MMIO, 32'h0000_BEEF, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (leds !== 16'hBEEF || cyc !== 1) begin errors++; $display("FAIL led_write: got leds %h cycles %0d expected beef 1", leds, cyc); end
        do_access(1'b1, 1'b0, MMIO, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL led_read: got %h expected 0000beef", rd); end
        do_access(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        exp = cyc_model;
        do_access(1'b1, 1'b0, MMIO + 32'h4, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (rd !== exp) begin errors++; $display("FAIL cycles_after_write: got %0d expected %0d", rd, exp); end
        do_access(1'b1, 1'b0, MMIO + 32'hC, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mmio_c_read: got %h expected 0", rd); end
        // A stray ack with no access must not start anything.
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || fsm_state !== 2'd0) begin
            errors++; $display("FAIL stray_ack: got req %b state %0d expected 0 0", mem_req, fsm_state);
        end
        leds_m = 16'hBEEF;
    endtask

    task automatic test_errors();
        int cyc, nreq; logic [31:0] rd, ra, rw; logic we, rq;
        do_access(1'b1, 1'b0, 32'h102, 32'h0, 1, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (rd !== 32'h0 || cyc !== 1 || nreq !== 0) begin
            errors++; $display("FAIL misaligned: got data %h cycles %0d reqs %0d expected 0 1 0", rd, cyc, nreq);
        end
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL misaligned_err: got %b expected 01", err); end
        do_access(1'b1, 1'b0, MMIO + 32'h8, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL err_read: got %h expected 1", rd); end
        do_access(1'b0, 1'b1, MMIO + 32'h8, 32'h0, 0, cyc, nreq, rd, ra, we, rw, rq);
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL err_clear2: got %b expected 00", err); end
        // Reset in the middle of REQ.
        cpu_read = 1'b1; cpu_addr = 32'h400; mem_ack = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_up: got %b expected 1", mem_req); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b0 || fsm_state !== 2'd0) begin
            errors++; $display("FAIL mid_reset: got req %b state %0d expected 0 0", mem_req, fsm_state);
        end
        cpu_read = 1'b0; rst = 1'b0;
        leds_m = 16'h0; err_m = 2'b00;
    endtask

    task automatic test_random();
        int cyc, nreq, kind, ack, exp_cyc; logic [31:0] rd, ra, rw, addr, wd; logic we, rq, r, w;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            wd   = $urandom;
            r = 1'b0; w = 1'b0; ack = 0; exp_cyc = 1;
            case (kind)
                0: begin
                    r = 1'b1; addr = 32'($urandom_range(0, 63)) << 2;
                    ack = $urandom_range(0, 5);
                    exp_cyc = (ack == 0) ? TIMEOUT + 2 : ack + 2;
                    exp_q.push_back((ack == 0) ? 32'hDEAD_BEEF : mem_val(addr));
                    if (ack == 0) err_m[1] = 1'b1;
                end
                1: begin
                    w = 1'b1; r = 1'($urandom_range(0, 1)); addr = 32'($urandom_range(0, 63)) << 2;
                    ack = $urandom_range(1, 5); exp_cyc = ack + 2;
                    exp_q.push_back(32'h0);
                end
                2: begin
                    w = 1'b1; addr = MMIO + (32'($urandom_range(0, 1)) << 2);
                    if (addr == MMIO) leds_m = wd[15:0];
                    exp_q.push_back(32'h0);
                end
                3: begin
                    r = 1'b1; addr = MMIO + (32'($urandom_range(0, 3)) << 2);
                    case (addr[3:2])
                        2'd0: exp_q.push_back({16'h0, leds_m});
                        2'd1: exp_q.push_back(cyc_model);
                        2'd2: exp_q.push_back({30'h0, err_m});
                        default: exp_q.push_back(32'h0);
                    endcase
                end
                4: begin
                    r = 1'b1; w = 1'($urandom_range(0, 1));
                    addr = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                    err_m[0] = 1'b1;
                    exp_q.push_back(32'h0);
                end
                default: begin
                    w = 1'b1; addr = MMIO + 32'h8; err_m = 2'b00;
                    exp_q.push_back(32'h0);
                end
            endcase
            do_access(r, w, addr, wd, ack, cyc, nreq, rd, ra, we, rw, rq);
            checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL rand_cycles[%0d]: got %0d expected %0d addr %h", i, cyc, exp_cyc, addr); end
            checks++; if (rd !== exp_q[0]) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h addr %h", i, rd, exp_q[0], addr); end
            void'(exp_q.pop_front());
            checks++; if (leds !== leds_m || err !== err_m) begin
                errors++; $display("FAIL rand_regs[%0d]: got leds %h err %b expected %h %b", i, leds, err, leds_m, err_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_mmio();
        test_errors();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
